// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter.
//   HDR_BYTES  : number of header bytes ahead of the payload (SA, DA, LEN x4, CRC x4)
//   tx_state_e : transmitter FSM states
//   hdr_byte() : maps a header byte index (0..9) to the byte placed on the wire
package router_pkg;

    localparam int HDR_BYTES = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BUSY = 3'd1,
        HDR       = 3'd2,
        PAYLOAD   = 3'd3,
        GAP       = 3'd4
    } tx_state_e;

    // Header layout: SA, DA, then LEN and CRC, each little-endian.
    function automatic logic [7:0] hdr_byte(
        input logic [3:0]  idx,
        input logic [7:0]  sa,
        input logic [7:0]  da,
        input logic [31:0] len,
        input logic [31:0] crc
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = sa;
            4'd1:    b = da;
            4'd2:    b = len[7:0];
            4'd3:    b = len[15:8];
            4'd4:    b = len[23:16];
            4'd5:    b = len[31:24];
            4'd6:    b = crc[7:0];
            4'd7:    b = crc[15:8];
            4'd8:    b = crc[23:16];
            4'd9:    b = crc[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// Synchronous byte FIFO holding the payload of the next packet.
//   clk, reset : clock, asynchronous active-high reset (flushes the FIFO)
//   wr_en      : write strobe, ignored when full
//   wr_data    : byte to write
//   rd_en      : pop strobe, ignored when empty
//   rd_data    : head of the FIFO (show-ahead, valid whenever not empty)
//   full/empty : occupancy flags
//   count      : bytes currently held (0..DEPTH)
module router_tx_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_ok;
    logic             rd_ok;

    // Pointers wrap naturally (DEPTH is a power of two); the count tells full from empty.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;

    // NOTE: the storage array is deliberately left out of reset; flushing only
    // needs the pointers and count cleared, and an unreset array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the router input (dut_inp/inp_valid).
// Payload bytes are buffered in a FIFO while a running checksum accumulates;
// pkt_start then emits SA, DA, LEN (10+N), CRC (sum of payload) and the payload
// as one contiguous byte stream, waiting for the router's busy to clear first.
//   clk, reset           : clock, asynchronous active-high reset
//   pkt_sa, pkt_da       : addresses, captured when pkt_start is accepted
//   pkt_start            : send the FIFO contents as one packet
//   pl_wr_en/pl_wr_data  : payload write, effective only while pl_wr_rdy
//   pl_wr_rdy            : IDLE and FIFO not full
//   pl_count             : bytes held in the FIFO
//   busy                 : router busy, a packet does not start while high
//   dut_inp/inp_valid    : registered byte stream (dut_inp is 0 when not valid)
//   tx_active            : high in WAIT_BUSY/HDR/PAYLOAD
//   tx_done              : pulse in the cycle after the last payload byte
//   tx_err               : pulse for a rejected pkt_start
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    pkt_sa,
    input  logic [7:0]                    pkt_da,
    input  logic                          pkt_start,
    input  logic                          pl_wr_en,
    input  logic [7:0]                    pl_wr_data,
    output logic                          pl_wr_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   pl_count,
    input  logic                          busy,
    output logic [7:0]                    dut_inp,
    output logic                          inp_valid,
    output logic                          tx_active,
    output logic                          tx_done,
    output logic                          tx_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // The byte index must reach HDR_BYTES-1 even for the smallest FIFO.
    localparam int IDX_W = (CNT_W > 4) ? CNT_W : 4;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    tx_state_e        state_q, state_d;
    logic [7:0]       sa_q, sa_d;
    logic [7:0]       da_q, da_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [31:0]      crc_q, crc_d;
    logic [7:0]       dut_inp_q, dut_inp_d;
    logic             inp_valid_q, inp_valid_d;
    logic             tx_active_q, tx_active_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_err_q, tx_err_d;

    logic             fifo_wr;
    logic             fifo_rd;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] n_avail;
    logic             start_ok;
    logic [IDX_W-1:0] idx_nxt;
    logic [31:0]      pkt_len;

    router_tx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (pl_wr_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign pl_wr_rdy = (state_q == IDLE) && !fifo_full;
    assign fifo_wr   = pl_wr_en && pl_wr_rdy;
    // A write in the same cycle as pkt_start belongs to the packet being started.
    assign n_avail   = fifo_count + CNT_W'(fifo_wr);
    assign start_ok  = pkt_start && (state_q == IDLE) && (!fifo_empty || fifo_wr);
    assign idx_nxt   = idx_q + IDX_W'(1);
    assign pkt_len   = 32'(HDR_BYTES) + 32'(n_q);

    // Each *_d value is the content shown on the outputs after the next edge,
    // so the stream leaves straight from registers.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can infer a latch.
        state_d     = state_q;
        sa_d        = sa_q;
        da_d        = da_q;
        n_d         = n_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        crc_d       = fifo_wr ? (crc_q + {24'h0, pl_wr_data}) : crc_q;
        fifo_rd     = 1'b0;
        dut_inp_d   = 8'h00;
        inp_valid_d = 1'b0;
        tx_done_d   = 1'b0;
        tx_err_d    = pkt_start && !start_ok;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    sa_d  = pkt_sa;
                    da_d  = pkt_da;
                    n_d   = n_avail;
                    idx_d = '0;
                    if (busy) begin
                        state_d = WAIT_BUSY;
                    end else begin
                        state_d     = HDR;
                        dut_inp_d   = pkt_sa;
                        inp_valid_d = 1'b1;
                    end
                end
            end
            WAIT_BUSY: begin
                if (!busy) begin
                    state_d     = HDR;
                    idx_d       = '0;
                    dut_inp_d   = sa_q;
                    inp_valid_d = 1'b1;
                end
            end
            HDR: begin
                inp_valid_d = 1'b1;
                if (idx_q == IDX_W'(HDR_BYTES - 1)) begin
                    state_d   = PAYLOAD;
                    idx_d     = '0;
                    fifo_rd   = 1'b1;
                    dut_inp_d = fifo_rdata;
                end else begin
                    idx_d     = idx_nxt;
                    dut_inp_d = hdr_byte(idx_nxt[3:0], sa_q, da_q, pkt_len, crc_q);
                end
            end
            PAYLOAD: begin
                if (idx_q == IDX_W'(n_q) - IDX_W'(1)) begin
                    tx_done_d = 1'b1;
                    crc_d     = '0;
                    // The IDLE cycle that samples the next pkt_start is the last
                    // forced idle cycle, so GAP itself holds GAP_CYCLES-1 cycles.
                    if (GAP_CYCLES > 1) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d       = idx_nxt;
                    fifo_rd     = 1'b1;
                    dut_inp_d   = fifo_rdata;
                    inp_valid_d = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 2)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_active_d = (state_d == WAIT_BUSY) || (state_d == HDR) || (state_d == PAYLOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sa_q        <= '0;
            da_q        <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            crc_q       <= '0;
            dut_inp_q   <= '0;
            inp_valid_q <= 1'b0;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            da_q        <= da_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            crc_q       <= crc_d;
            dut_inp_q   <= dut_inp_d;
            inp_valid_q <= inp_valid_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
            tx_err_q    <= tx_err_d;
        end
    end

    assign pl_count  = fifo_count;
    assign dut_inp   = dut_inp_q;
    assign inp_valid = inp_valid_q;
    assign tx_active = tx_active_q;
    assign tx_done   = tx_done_q;
    assign tx_err    = tx_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed scenarios plus random traffic,
// compared each cycle against a packet-level timeline model.
module tb_router_pkt_tx;

    localparam int DEPTH = 64;
    localparam int GAP   = 2;
    localparam int HDR   = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pkt_sa, pkt_da, pl_wr_data;
    logic       pkt_start, pl_wr_en, busy;
    logic       pl_wr_rdy;
    logic [6:0] pl_count;
    logic [7:0] dut_inp;
    logic       inp_valid, tx_active, tx_done, tx_err;

    always #5 clk = ~clk;

    router_pkt_tx #(
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pkt_sa     (pkt_sa),
        .pkt_da     (pkt_da),
        .pkt_start  (pkt_start),
        .pl_wr_en   (pl_wr_en),
        .pl_wr_data (pl_wr_data),
        .pl_wr_rdy  (pl_wr_rdy),
        .pl_count   (pl_count),
        .busy       (busy),
        .dut_inp    (dut_inp),
        .inp_valid  (inp_valid),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Model: payload waiting to be sent, plus the timeline of the current packet.
    // Wire byte j of the packet appears in the cycle after edge p_s + j.
    logic [7:0] mq[$];
    logic [7:0] pkt[$];
    int         p_n = 0;
    int         p_s = 0;
    bit         have_pkt = 0;
    bit         pending = 0;
    bit         err_exp = 0;

    logic [7:0] wire_log[$];
    int         zrun = 0;
    bit         seen_pkt = 0;
    int         last_gap = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit model_idle(input int c);
        return !pending && (!have_pkt || c >= p_s + HDR - 1 + p_n + GAP);
    endfunction

    function automatic int model_remaining(input int c);
        int sent;
        if (pending) return p_n;
        if (!have_pkt) return 0;
        sent = c - (p_s + HDR) + 1;
        if (sent < 0) sent = 0;
        if (sent > p_n) sent = p_n;
        return p_n - sent;
    endfunction

    // One clock cycle: check this cycle's outputs, drive inputs, advance the model.
    task automatic step(input bit wr, input logic [7:0] d, input bit st,
                        input logic [7:0] sa, input logic [7:0] da, input bit bz);
        int          j;
        int          n;
        bit          on;
        bit          idle;
        logic [7:0]  eb;
        logic [31:0] sum;
        logic [31:0] len;
        j    = cyc - p_s;
        on   = have_pkt && (j >= 0) && (j < HDR + p_n);
        eb   = on ? pkt[j] : 8'h00;
        idle = model_idle(cyc);
        check("inp_valid", 32'(inp_valid), 32'(on));
        check("dut_inp", 32'(dut_inp), 32'(eb));
        check("tx_done", 32'(tx_done), 32'(have_pkt && (j == HDR + p_n)));
        check("tx_err", 32'(tx_err), 32'(err_exp));
        check("tx_active", 32'(tx_active), 32'(pending || on));
        check("pl_count", 32'(pl_count), 32'(mq.size() + model_remaining(cyc)));
        check("pl_wr_rdy", 32'(pl_wr_rdy), 32'(idle && (mq.size() < DEPTH)));

        if (inp_valid) begin
            wire_log.push_back(dut_inp);
            if (seen_pkt && zrun > 0) last_gap = zrun;
            zrun     = 0;
            seen_pkt = 1;
        end else begin
            zrun++;
        end

        pl_wr_en   = wr;
        pl_wr_data = d;
        pkt_start  = st;
        pkt_sa     = sa;
        pkt_da     = da;
        busy       = bz;

        err_exp = 0;
        if (idle && wr && mq.size() < DEPTH) mq.push_back(d);
        if (pending && !bz) begin
            pending  = 0;
            have_pkt = 1;
            p_s      = cyc + 1;
        end
        if (st) begin
            if (idle && mq.size() > 0) begin
                n   = mq.size();
                sum = 0;
                foreach (mq[i]) sum += 32'(mq[i]);
                len = 32'(HDR + n);
                pkt.delete();
                pkt.push_back(sa);
                pkt.push_back(da);
                for (int b = 0; b < 4; b++) pkt.push_back(len[8*b +: 8]);
                for (int b = 0; b < 4; b++) pkt.push_back(sum[8*b +: 8]);
                foreach (mq[i]) pkt.push_back(mq[i]);
                mq.delete();
                p_n = n;
                if (bz) begin
                    pending  = 1;
                    have_pkt = 0;
                end else begin
                    have_pkt = 1;
                    p_s      = cyc + 1;
                end
            end else begin
                err_exp = 1;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_step(input bit bz);
        step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, bz);
    endtask

    task automatic run_idle(input bit rand_busy);
        for (int k = 0; k < 2000 && !model_idle(cyc); k++) begin
            idle_step(rand_busy ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        step(1'b1, d, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_inp_valid", 32'(inp_valid), 32'd0);
        check("rst_dut_inp", 32'(dut_inp), 32'd0);
        check("rst_pl_count", 32'(pl_count), 32'd0);
        check("rst_pl_wr_rdy", 32'(pl_wr_rdy), 32'd1);
        pl_wr_en  = 1'b0;
        pkt_start = 1'b0;
        busy      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc += 2;
        mq.delete();
        pending  = 0;
        have_pkt = 0;
        err_exp  = 0;
        seen_pkt = 0;
        zrun     = 0;
    endtask

    initial begin
        logic [7:0] t1 [13];
        int         stop;

        reset      = 1'b1;
        pkt_sa     = 8'h00;
        pkt_da     = 8'h00;
        pkt_start  = 1'b0;
        pl_wr_en   = 1'b0;
        pl_wr_data = 8'h00;
        busy       = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_pl_wr_rdy", 32'(pl_wr_rdy), 32'd1);
        check("reset_tx_active", 32'(tx_active), 32'd0);
        reset = 1'b0;
        cyc   = 0;

        // Basic three-byte packet.
        t1 = '{8'h11, 8'h22, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00,
               8'h01, 8'h02, 8'h03};
        wire_log.delete();
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        step(1'b0, 8'h00, 1'b1, 8'h11, 8'h22, 1'b0);
        run_idle(1'b0);
        check("t1_len", 32'(wire_log.size()), 32'd13);
        for (int i = 0; i < 13 && i < wire_log.size(); i++) check("t1_byte", 32'(wire_log[i]), 32'(t1[i]));

        // Router busy at start, held for five cycles.
        write_byte(8'hAA);
        write_byte(8'h55);
        step(1'b0, 8'h00, 1'b1, 8'h31, 8'h42, 1'b1);
        repeat (4) idle_step(1'b1);
        run_idle(1'b0);

        // Rejected starts: empty FIFO, then while transmitting.
        step(1'b0, 8'h00, 1'b1, 8'h01, 8'h02, 1'b0);
        idle_step(1'b0);
        for (int i = 0; i < 4; i++) write_byte(8'(8'h10 + i));
        step(1'b0, 8'h00, 1'b1, 8'h05, 8'h06, 1'b0);
        stop = p_s + HDR + 1;
        for (int k = 0; k < 100 && cyc < stop; k++) idle_step(1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h77, 8'h88, 1'b0);
        run_idle(1'b0);

        // Full FIFO: the 65th write is dropped.
        wire_log.delete();
        repeat (65) write_byte(8'hFF);
        step(1'b0, 8'h00, 1'b1, 8'hA1, 8'hB2, 1'b0);
        run_idle(1'b0);
        check("t4_len", 32'(wire_log.size()), 32'd74);
        if (wire_log.size() >= 74) begin
            check("t4_LEN0", 32'(wire_log[2]), 32'h4A);
            check("t4_LEN1", 32'(wire_log[3]), 32'h00);
            check("t4_CRC0", 32'(wire_log[6]), 32'hC0);
            check("t4_CRC1", 32'(wire_log[7]), 32'h3F);
            check("t4_CRC2", 32'(wire_log[8]), 32'h00);
            check("t4_CRC3", 32'(wire_log[9]), 32'h00);
            for (int i = 10; i < 74; i++) check("t4_payload", 32'(wire_log[i]), 32'hFF);
        end

        // Reset during the fifth payload byte, then a one-byte packet.
        for (int i = 0; i < 8; i++) write_byte(8'($urandom));
        step(1'b0, 8'h00, 1'b1, 8'h3C, 8'h4D, 1'b0);
        stop = p_s + HDR + 4;
        for (int k = 0; k < 100 && cyc < stop; k++) idle_step(1'b0);
        do_reset();
        wire_log.delete();
        step(1'b1, 8'h5A, 1'b1, 8'h12, 8'h34, 1'b0);
        run_idle(1'b0);
        check("t5_len", 32'(wire_log.size()), 32'd11);
        if (wire_log.size() >= 11) begin
            check("t5_sa", 32'(wire_log[0]), 32'h12);
            check("t5_LEN", 32'(wire_log[2]), 32'h0B);
            check("t5_CRC", 32'(wire_log[6]), 32'h5A);
            check("t5_payload", 32'(wire_log[10]), 32'h5A);
        end

        // Back-to-back packets with busy toggling during transmission.
        write_byte(8'h21);
        step(1'b1, 8'h22, 1'b1, 8'h61, 8'h62, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_idle(1'b1);
            last_gap = -1;
            step(1'b1, 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'b0);
            run_idle(1'b1);
            check("b2b_gap", 32'(last_gap), 32'(GAP));
        end

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            step(1'($urandom_range(0, 99) < 50), 8'($urandom),
                 1'($urandom_range(0, 99) < 5), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 99) < 30));
        end
        run_idle(1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
